// File: rtl/scoreboard_if.sv
// Scoreboard bus: allocation, writeback, redirect and commit signals.
// The master drives allocation/writeback/redirect; the slave (scoreboard) drives status and commits.
interface scoreboard_if #(
   parameter int unsigned SB_W = 3
) ();

   // Allocation
   logic            alloc0_valid_i;
   logic [4:0]      alloc0_rd_i;
   logic            alloc1_valid_i;
   logic [4:0]      alloc1_rd_i;
   logic            alloc_ready_o;
   logic [SB_W:0]   alloc0_sid_o;
   logic [SB_W:0]   alloc1_sid_o;

   // Writeback
   logic            wb0_valid_i;
   logic [SB_W:0]   wb0_sid_i;
   logic [63:0]     wb0_value_i;
   logic            wb1_valid_i;
   logic [SB_W:0]   wb1_sid_i;
   logic [63:0]     wb1_value_i;

   // Redirect
   logic            redirect_i;
   logic [SB_W:0]   redirect_sid_i;

   // Commit
   logic            commit0_valid_o;
   logic [4:0]      commit0_rd_o;
   logic [63:0]     commit0_value_o;
   logic [SB_W:0]   commit0_sid_o;
   logic            commit1_valid_o;
   logic [4:0]      commit1_rd_o;
   logic [63:0]     commit1_value_o;
   logic [SB_W:0]   commit1_sid_o;

   // Occupancy
   logic [SB_W:0]   count_o;
   logic            full_o;
   logic            empty_o;

   modport master (
      output alloc0_valid_i, alloc0_rd_i, alloc1_valid_i, alloc1_rd_i,
      output wb0_valid_i, wb0_sid_i, wb0_value_i,
      output wb1_valid_i, wb1_sid_i, wb1_value_i,
      output redirect_i, redirect_sid_i,
      input  alloc_ready_o, alloc0_sid_o, alloc1_sid_o,
      input  commit0_valid_o, commit0_rd_o, commit0_value_o, commit0_sid_o,
      input  commit1_valid_o, commit1_rd_o, commit1_value_o, commit1_sid_o,
      input  count_o, full_o, empty_o
   );

   modport slave (
      input  alloc0_valid_i, alloc0_rd_i, alloc1_valid_i, alloc1_rd_i,
      input  wb0_valid_i, wb0_sid_i, wb0_value_i,
      input  wb1_valid_i, wb1_sid_i, wb1_value_i,
      input  redirect_i, redirect_sid_i,
      output alloc_ready_o, alloc0_sid_o, alloc1_sid_o,
      output commit0_valid_o, commit0_rd_o, commit0_value_o, commit0_sid_o,
      output commit1_valid_o, commit1_rd_o, commit1_value_o, commit1_sid_o,
      output count_o, full_o, empty_o
   );

endinterface

// File: rtl/scoreboard.sv
// In-order completion scoreboard: allocates sids for a dual-issue pair, records out-of-order
// writeback results, and retires up to two completed entries per cycle in program order.
// A redirect truncates the window so that the redirecting sid is the youngest survivor.
module scoreboard #(
   parameter int unsigned SB_W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   scoreboard_if.slave  sb
);

   localparam int unsigned DEPTH = 1 << SB_W;

   typedef logic [SB_W:0]   sid_t;
   typedef logic [SB_W-1:0] idx_t;

   // Registered state
   sid_t             r_head;
   sid_t             r_tail;
   logic [DEPTH-1:0] r_done;
   logic [4:0]       r_rd    [DEPTH];
   logic [63:0]      r_value [DEPTH];

   // Next-state and derived signals
   sid_t             w_head_d;
   sid_t             w_tail_d;
   logic [DEPTH-1:0] w_done_d;
   sid_t             w_count;
   sid_t             w_tail1;
   sid_t             w_ncommit;
   idx_t             w_hidx;
   idx_t             w_h1idx;
   idx_t             w_tidx;
   idx_t             w_t1idx;
   logic             w_empty;
   logic             w_ready;
   logic             w_c0;
   logic             w_c1;
   logic             w_alloc0;
   logic             w_alloc1;
   sid_t             w_rpos;
   sid_t             w_wb0_off;
   sid_t             w_wb1_off;
   logic             w_wb0_ok;
   logic             w_wb1_ok;
   logic [DEPTH-1:0] w_squash;

   assign w_count = r_tail - r_head;
   assign w_empty = (w_count == '0);
   assign w_ready = (w_count <= sid_t'(DEPTH - 2));
   assign w_tail1 = r_tail + sid_t'(1);
   assign w_hidx  = r_head[SB_W-1:0];
   assign w_h1idx = w_hidx + idx_t'(1);
   assign w_tidx  = r_tail[SB_W-1:0];
   assign w_t1idx = w_tail1[SB_W-1:0];

   // Commit eligibility comes from registered state only
   assign w_c0      = !w_empty && r_done[w_hidx];
   assign w_c1      = w_c0 && (w_count >= sid_t'(2)) && r_done[w_h1idx];
   assign w_ncommit = {{SB_W{1'b0}}, w_c0} + {{SB_W{1'b0}}, w_c1};

   // A redirect takes priority over allocation in the same cycle
   assign w_alloc0 = sb.alloc0_valid_i && w_ready && !sb.redirect_i;
   assign w_alloc1 = w_alloc0 && sb.alloc1_valid_i;

   // Wrap-aware window offsets relative to head
   assign w_rpos    = sb.redirect_sid_i - r_head;
   assign w_wb0_off = sb.wb0_sid_i - r_head;
   assign w_wb1_off = sb.wb1_sid_i - r_head;

   // Writeback lands only inside the window and, under redirect, only on survivors
   assign w_wb0_ok = sb.wb0_valid_i && (w_wb0_off < w_count) &&
                     (!sb.redirect_i || (w_wb0_off <= w_rpos));
   assign w_wb1_ok = sb.wb1_valid_i && (w_wb1_off < w_count) &&
                     (!sb.redirect_i || (w_wb1_off <= w_rpos));

   // Per-entry squash flag: entry lies in the window strictly younger than the redirect sid
   for (genvar g = 0; g < DEPTH; g++) begin : g_squash
      idx_t w_pos;
      assign w_pos       = idx_t'(g) - w_hidx;
      assign w_squash[g] = sb.redirect_i && ({1'b0, w_pos} > w_rpos) &&
                           ({1'b0, w_pos} < w_count);
   end

   // Next-state for head, tail and done bits
   always_comb begin
      w_head_d = r_head + w_ncommit;
      w_tail_d = r_tail;
      if (sb.redirect_i) begin
         w_tail_d = sb.redirect_sid_i + sid_t'(1);
      end else if (w_alloc1) begin
         w_tail_d = r_tail + sid_t'(2);
      end else if (w_alloc0) begin
         w_tail_d = w_tail1;
      end

      w_done_d = r_done;
      if (w_c0) w_done_d[w_hidx] = 1'b0;
      if (w_c1) w_done_d[w_h1idx] = 1'b0;
      w_done_d = w_done_d & ~w_squash;
      if (w_alloc0) w_done_d[w_tidx] = 1'b0;
      if (w_alloc1) w_done_d[w_t1idx] = 1'b0;
      if (w_wb0_ok) w_done_d[w_wb0_off[SB_W-1:0] + w_hidx] = 1'b1;
      if (w_wb1_ok) w_done_d[w_wb1_off[SB_W-1:0] + w_hidx] = 1'b1;
   end

   // State registers; every entry clears on reset so outputs read zero afterwards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head <= '0;
         r_tail <= '0;
         r_done <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_rd[i]    <= '0;
            r_value[i] <= '0;
         end
      end else begin
         r_head <= w_head_d;
         r_tail <= w_tail_d;
         r_done <= w_done_d;
         if (w_alloc0) r_rd[w_tidx] <= sb.alloc0_rd_i;
         if (w_alloc1) r_rd[w_t1idx] <= sb.alloc1_rd_i;
         if (w_wb0_ok) r_value[sb.wb0_sid_i[SB_W-1:0]] <= sb.wb0_value_i;
         if (w_wb1_ok) r_value[sb.wb1_sid_i[SB_W-1:0]] <= sb.wb1_value_i;
      end
   end

   // Outputs; commit payloads read zero when not retiring
   always_comb begin
      sb.alloc_ready_o   = w_ready;
      sb.alloc0_sid_o    = r_tail;
      sb.alloc1_sid_o    = w_tail1;
      sb.count_o         = w_count;
      sb.empty_o         = w_empty;
      sb.full_o          = (w_count == sid_t'(DEPTH));
      sb.commit0_valid_o = w_c0;
      sb.commit0_rd_o    = w_c0 ? r_rd[w_hidx] : '0;
      sb.commit0_value_o = w_c0 ? r_value[w_hidx] : '0;
      sb.commit0_sid_o   = w_c0 ? r_head : '0;
      sb.commit1_valid_o = w_c1;
      sb.commit1_rd_o    = w_c1 ? r_rd[w_h1idx] : '0;
      sb.commit1_value_o = w_c1 ? r_value[w_h1idx] : '0;
      sb.commit1_sid_o   = w_c1 ? (r_head + sid_t'(1)) : '0;
   end

   // Redirect must name a live sid; the two writeback ports must not collide
   a_redirect_in_window : assert property (@(posedge clk) disable iff (!rst_n)
      sb.redirect_i |-> (w_rpos < w_count));
   a_wb_distinct : assert property (@(posedge clk) disable iff (!rst_n)
      (sb.wb0_valid_i && sb.wb1_valid_i) |-> (sb.wb0_sid_i != sb.wb1_sid_i));

endmodule
